// File: rtl/pattern_recorder.sv
// pattern_recorder: packs note events into 16-bit pattern words and writes them to
// consecutive addresses of a synchronous pattern RAM, closing the pattern with an
// end-marker word (16'h8000).
//
// Word format: [15] end flag, [14:9] note, [8:4] length, [3:0] instrument.
//
// Ports:
//   i_clk          system clock
//   i_rst          synchronous active-high reset
//   i_note_valid   note event present
//   o_note_ready   recorder can take an event this cycle (IDLE only)
//   i_note         note number
//   i_note_len     note length in note-strobe ticks
//   i_instrument   instrument index
//   i_finish       single-cycle request to terminate the pattern
//   o_ram_we       RAM write strobe, one cycle per word
//   o_ram_addr     RAM write address
//   o_ram_data     packed pattern word
//   o_count        note words written so far (end marker excluded)
//   o_busy         high from the first accepted note until DONE
//   o_done         end marker written; sticky until reset
//   o_overflow     sticky: a note was dropped because the pattern was full
//
// DEPTH must be a power of two in 4..256; ADDR_W = clog2(DEPTH).

module pattern_recorder #(
  parameter int unsigned DEPTH  = 256,
  parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_note_valid,
  output logic              o_note_ready,
  input  logic [5:0]        i_note,
  input  logic [4:0]        i_note_len,
  input  logic [3:0]        i_instrument,
  input  logic              i_finish,
  output logic              o_ram_we,
  output logic [ADDR_W-1:0] o_ram_addr,
  output logic [15:0]       o_ram_data,
  output logic [ADDR_W:0]   o_count,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_overflow
);

  typedef enum logic [1:0] {
    StIdle,
    StEnd,
    StDone
  } state_e;

  localparam logic [15:0]     EndMarker = 16'h8000;
  // The last RAM slot is reserved for the end marker.
  localparam logic [ADDR_W:0] LastSlot  = (ADDR_W + 1)'(DEPTH - 1);
  localparam logic [ADDR_W:0] CountOne  = (ADDR_W + 1)'(1);

  state_e              state_q, state_d;
  logic                ram_we_q, ram_we_d;
  logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
  logic [15:0]         ram_data_q, ram_data_d;
  logic [ADDR_W:0]     count_q, count_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                overflow_q, overflow_d;
  logic                accept;

  assign o_note_ready = (state_q == StIdle);
  assign accept       = i_note_valid && o_note_ready;

  always_comb begin
    state_d    = state_q;
    ram_we_d   = 1'b0;
    ram_addr_d = ram_addr_q;
    ram_data_d = ram_data_q;
    count_d    = count_q;
    busy_d     = busy_q;
    done_d     = done_q;
    overflow_d = overflow_q;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          busy_d = 1'b1;
          if (count_q < LastSlot) begin
            ram_we_d   = 1'b1;
            ram_addr_d = count_q[ADDR_W-1:0];
            ram_data_d = {1'b0, i_note, i_note_len, i_instrument};
            count_d    = count_q + CountOne;
          end else begin
            // Full: consume and drop so the source never stalls.
            overflow_d = 1'b1;
          end
        end
        // A note accepted alongside finish is written first; the marker follows.
        if (i_finish) begin
          state_d = StEnd;
        end
      end

      StEnd: begin
        // count_q <= DEPTH-1 here, so the address cannot wrap.
        ram_we_d   = 1'b1;
        ram_addr_d = count_q[ADDR_W-1:0];
        ram_data_d = EndMarker;
        busy_d     = 1'b0;
        done_d     = 1'b1;
        state_d    = StDone;
      end

      StDone: begin
        // Terminal until reset; valid and finish are ignored.
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= StIdle;
      ram_we_q   <= 1'b0;
      ram_addr_q <= '0;
      ram_data_q <= '0;
      count_q    <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ram_we_q   <= ram_we_d;
      ram_addr_q <= ram_addr_d;
      ram_data_q <= ram_data_d;
      count_q    <= count_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      overflow_q <= overflow_d;
    end
  end

  assign o_ram_we   = ram_we_q;
  assign o_ram_addr = ram_addr_q;
  assign o_ram_data = ram_data_q;
  assign o_count    = count_q;
  assign o_busy     = busy_q;
  assign o_done     = done_q;
  assign o_overflow = overflow_q;

endmodule

// File: tb/tb_pattern_recorder.sv
// Self-checking bench for pattern_recorder. Two instances share one stimulus stream:
// index 0 uses DEPTH=256, index 1 uses DEPTH=4 (exercises the full/drop path).
// Each instance is compared every cycle against a transaction-level reference model.

module tb_pattern_recorder;

  logic       clk = 1'b0;
  logic       rst;
  logic       valid;
  logic [5:0] note;
  logic [4:0] len;
  logic [3:0] instr;
  logic       finish;

  logic       ready0, we0, busy0, done0, ovf0;
  logic [7:0] addr0;
  logic [15:0] data0;
  logic [8:0] count0;

  logic       ready1, we1, busy1, done1, ovf1;
  logic [1:0] addr1;
  logic [15:0] data1;
  logic [2:0] count1;

  int checks = 0;
  int errors = 0;

  // Reference model state per instance.
  int          depth_of [2] = '{256, 4};
  int          m_count  [2];
  int          m_addr   [2];
  int          m_phase  [2];  // 0 open, 1 marker due, 2 closed
  logic [15:0] m_data   [2];
  bit          m_we     [2];
  bit          m_busy   [2];
  bit          m_done   [2];
  bit          m_ovf    [2];
  bit          m_chk_ad [2];
  bit          m_known = 1'b0;

  pattern_recorder #(.DEPTH(256), .ADDR_W(8)) dut0 (
    .i_clk(clk), .i_rst(rst), .i_note_valid(valid), .o_note_ready(ready0),
    .i_note(note), .i_note_len(len), .i_instrument(instr), .i_finish(finish),
    .o_ram_we(we0), .o_ram_addr(addr0), .o_ram_data(data0), .o_count(count0),
    .o_busy(busy0), .o_done(done0), .o_overflow(ovf0)
  );

  pattern_recorder #(.DEPTH(4), .ADDR_W(2)) dut1 (
    .i_clk(clk), .i_rst(rst), .i_note_valid(valid), .o_note_ready(ready1),
    .i_note(note), .i_note_len(len), .i_instrument(instr), .i_finish(finish),
    .o_ram_we(we1), .o_ram_addr(addr1), .o_ram_data(data1), .o_count(count1),
    .o_busy(busy1), .o_done(done1), .o_overflow(ovf1)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance the model by one clock given the inputs seen at that edge.
  task automatic model_step(input bit v, input int n, input int l, input int i,
                            input bit f, input bit r);
    for (int k = 0; k < 2; k++) begin
      if (r) begin
        m_count[k] = 0; m_addr[k] = 0; m_data[k] = '0; m_phase[k] = 0;
        m_we[k] = 0; m_busy[k] = 0; m_done[k] = 0; m_ovf[k] = 0; m_chk_ad[k] = 1;
      end else begin
        m_we[k] = 0;
        m_chk_ad[k] = 0;
        if (m_phase[k] == 1) begin
          m_we[k] = 1; m_addr[k] = m_count[k]; m_data[k] = 16'h8000; m_chk_ad[k] = 1;
          m_phase[k] = 2; m_done[k] = 1; m_busy[k] = 0;
        end else if (m_phase[k] == 0) begin
          if (v) begin
            m_busy[k] = 1;
            if (m_count[k] < depth_of[k] - 1) begin
              m_we[k] = 1; m_addr[k] = m_count[k]; m_chk_ad[k] = 1;
              m_data[k] = 16'(n * 512 + l * 16 + i);
              m_count[k]++;
            end else begin
              m_ovf[k] = 1;
            end
          end
          if (f) m_phase[k] = 1;
        end
      end
    end
    if (r) m_known = 1'b1;
  endtask

  task automatic compare_outputs();
    check("we0", 32'(we0), 32'(m_we[0]));
    check("count0", 32'(count0), 32'(m_count[0]));
    check("busy0", 32'(busy0), 32'(m_busy[0]));
    check("done0", 32'(done0), 32'(m_done[0]));
    check("ovf0", 32'(ovf0), 32'(m_ovf[0]));
    if (m_chk_ad[0]) begin
      check("addr0", 32'(addr0), 32'(m_addr[0]));
      check("data0", 32'(data0), 32'(m_data[0]));
    end
    check("we1", 32'(we1), 32'(m_we[1]));
    check("count1", 32'(count1), 32'(m_count[1]));
    check("busy1", 32'(busy1), 32'(m_busy[1]));
    check("done1", 32'(done1), 32'(m_done[1]));
    check("ovf1", 32'(ovf1), 32'(m_ovf[1]));
    if (m_chk_ad[1]) begin
      check("addr1", 32'(addr1), 32'(m_addr[1]));
      check("data1", 32'(data1), 32'(m_data[1]));
    end
  endtask

  // One clock: drive inputs, check ready (state-only), clock, check outputs.
  task automatic cycle(input bit v, input int n, input int l, input int i,
                       input bit f, input bit r);
    valid = v; note = 6'(n); len = 5'(l); instr = 4'(i); finish = f; rst = r;
    if (m_known) begin
      check("ready0", 32'(ready0), 32'(m_phase[0] == 0));
      check("ready1", 32'(ready1), 32'(m_phase[1] == 0));
    end
    model_step(v, n, l, i, f, r);
    @(posedge clk);
    #1;
    if (m_known) compare_outputs();
  endtask

  task automatic idle(input int cycles);
    for (int c = 0; c < cycles; c++) cycle(0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    cycle(0, 0, 0, 0, 0, 1);
  endtask

  initial begin
    valid = 0; note = 0; len = 0; instr = 0; finish = 0; rst = 1;
    @(posedge clk);
    #1;

    // Reset state.
    do_reset();
    check("rst_we", 32'(we0), 32'h0);
    check("rst_data", 32'(data0), 32'h0);
    check("rst_ready", 32'(ready0), 32'h1);
    idle(2);

    // Single note, one cycle latency.
    cycle(1, 6'h15, 8, 3, 0, 0);
    check("single_data", 32'(data0), 32'h2A83);
    check("single_addr", 32'(addr0), 32'h0);
    check("single_busy", 32'(busy0), 32'h1);
    idle(2);

    // Burst of 4 then finish.
    do_reset();
    for (int k = 0; k < 4; k++) cycle(1, $urandom_range(63), $urandom_range(31),
                                      $urandom_range(15), 0, 0);
    cycle(0, 0, 0, 0, 1, 0);
    idle(3);
    check("burst_count", 32'(count0), 32'h4);
    check("burst_ready", 32'(ready0), 32'h0);

    // Note and finish in the same cycle.
    do_reset();
    cycle(1, 1, 1, 1, 1, 0);
    check("simul_data", 32'(data0), 32'h0211);
    cycle(0, 0, 0, 0, 0, 0);
    check("simul_marker", 32'(data0), 32'h8000);
    check("simul_maddr", 32'(addr0), 32'h1);
    idle(2);

    // Full on the DEPTH=4 instance: five notes then finish.
    do_reset();
    for (int k = 0; k < 5; k++) cycle(1, k + 1, k, k, 0, 0);
    cycle(0, 0, 0, 0, 1, 0);
    cycle(0, 0, 0, 0, 0, 0);
    check("full_marker_addr", 32'(addr1), 32'h3);
    check("full_ovf", 32'(ovf1), 32'h1);
    check("full_count", 32'(count1), 32'h3);
    idle(2);

    // Empty pattern and DONE lockout; len=0 note rejected by lockout.
    do_reset();
    cycle(0, 0, 0, 0, 1, 0);
    idle(2);
    check("empty_count", 32'(count0), 32'h0);
    for (int k = 0; k < 4; k++) cycle(1, 7, 0, 2, k[0], 0);

    // Reset mid-burst during the second write cycle.
    do_reset();
    cycle(1, 3, 4, 5, 0, 0);
    cycle(1, 6, 7, 8, 0, 0);
    cycle(1, 9, 9, 9, 0, 1);
    check("midrst_ready", 32'(ready0), 32'h1);
    cycle(1, 2, 0, 1, 0, 0);
    check("midrst_addr", 32'(addr0), 32'h0);
    idle(1);

    // Randomised sessions.
    for (int s = 0; s < 25; s++) begin
      do_reset();
      for (int c = 0; c < 12; c++) begin
        cycle($urandom_range(3) != 0, $urandom_range(63), $urandom_range(31),
              $urandom_range(15), $urandom_range(9) == 0, $urandom_range(40) == 0);
      end
      idle(3);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pattern_recorder.md
Name: pattern_recorder

Overview:
Writer-side counterpart of pattern_sequencer. It accepts note events (note, length, instrument) over a valid/ready handshake and packs each one into a 16-bit pattern word. Each word is written to sequential addresses of a synchronous pattern RAM, and an end-of-pattern marker word closes the pattern. It sits between a pattern source (host/UART loader or live-entry logic) and the RAM that pattern_sequencer later reads as its ROM.

Parameters:
DEPTH, 256, number of pattern words in the RAM; must be a power of two, 4..256.
ADDR_W, 8, RAM address width; clog2(DEPTH).

Ports:
i_clk  input  1  system clock
i_rst  input  1  synchronous active-high reset
i_note_valid  input  1  note event present
o_note_ready  output  1  recorder can take an event this cycle
i_note  input  6  note number
i_note_len  input  5  note length in note-strobe ticks
i_instrument  input  4  instrument index
i_finish  input  1  single-cycle request to terminate the pattern
o_ram_we  output  1  RAM write strobe, one cycle per word
o_ram_addr  output  ADDR_W  RAM write address
o_ram_data  output  16  packed pattern word
o_count  output  ADDR_W+1  note words written so far; excludes the end marker
o_busy  output  1  high from the first accepted note until DONE
o_done  output  1  end marker written; sticky until reset
o_overflow  output  1  sticky: a note was dropped because the pattern was full

Behaviour:
- Word format:
  - bit15 = end flag; bits14:9 = note; bits8:4 = len; bits3:0 = instrument.
  - Note words always have bit15 = 0.
  - End marker = 16'h8000.
  - len = 0 is legal and is written unmodified.
- Reset values:
  - o_ram_we=0, o_ram_addr=0, o_ram_data=0.
  - o_count=0, o_busy=0, o_done=0, o_overflow=0.
  - FSM = IDLE.
  - Reset mid-pattern abandons the pattern with no marker write; RAM contents are untouched.
- All outputs are registered. o_note_ready is combinational from state only: ready = (state==IDLE).
- FSM states and transitions:
  - IDLE
    - Accept when i_note_valid && o_note_ready.
    - If o_count < DEPTH-1: the next cycle has o_ram_we=1, o_ram_addr=o_count (pre-increment), o_ram_data=packed word. o_count increments in that same cycle. o_busy is set.
    - If o_count == DEPTH-1 (last slot reserved for the marker): the event is consumed but dropped. o_overflow is set, with no write and no count change. Upstream never stalls.
    - Accepts may be back-to-back, one word per cycle. o_ram_we is high only in cycles that follow an accept or finish.
    - i_finish → go to END. If an accept occurs in the same cycle, that note is written first (cycle k+1) and the marker follows at k+2.
  - END
    - One cycle. Writes o_ram_data=16'h8000 at o_ram_addr=o_count; o_count does not increment.
    - Then go to DONE.
  - DONE
    - o_done=1, o_busy=0, ready=0.
    - i_note_valid and i_finish are ignored.
    - Left only by i_rst.
- An empty pattern is legal: i_finish with o_count=0 writes the marker at address 0.
- Address arithmetic never wraps, because the full check keeps o_count ≤ DEPTH-1.

Test Plan:
- Single note: reset, then valid with note=6'h15, len=5'd8, instr=4'h3 → exactly one cycle later: we=1, addr=0, data=16'h2A83; o_count=1; o_busy=1.
- Burst: 4 notes on consecutive cycles, then i_finish → writes at addr 0..3 on 4 consecutive cycles, marker 16'h8000 at addr 4, then o_done=1, o_count=4, ready=0.
- Simultaneous note and finish: valid+finish together with note=1, len=1, instr=1 → data 16'h0211 at addr 0, then 16'h8000 at addr 1 on the next cycle.
- Full: DEPTH=4; send 5 notes, then finish → addr 0..2 written, 4th and 5th notes dropped, o_overflow=1, o_count=3, marker at addr 3.
- Empty pattern and DONE lockout: i_finish alone → marker at addr 0, o_count=0. Subsequent valid/finish pulses produce no we.
- Reset mid-burst: assert i_rst during the 2nd write cycle → next cycle all outputs are 0 and ready=1. A new note is then written at addr 0.
